// File: rtl/vga_bounce_renderer_pkg.sv
// vga_bounce_renderer_pkg: shared resolution defaults, colour constants and motion FSM states
package vga_bounce_renderer_pkg;
  localparam int RGB_W = 6;
  localparam int H_RES_D = 640;
  localparam int V_RES_D = 480;
  localparam logic [RGB_W-1:0] SPR_COLOR_D = 6'b110000;
  localparam logic [RGB_W-1:0] BG_A_D = 6'b000001;
  localparam logic [RGB_W-1:0] BG_B_D = 6'b000010;
  typedef enum logic [1:0] {IDLE, UPDATE, HOLD} state_t;
  // rotate a colour left by whole 2-bit channels
  function automatic logic [RGB_W-1:0] rotl_col(input logic [RGB_W-1:0] c, input logic [1:0] n);
    logic [2*RGB_W-1:0] d;
    d = {c, c} << {n, 1'b0};
    return d[2*RGB_W-1:RGB_W];
  endfunction
endpackage

// File: rtl/vga_bounce_renderer_bounce_axis.sv
// bounce_axis: one sprite axis position and direction, clamped bounce at 0 and LIMIT-SIZE
module bounce_axis #(
  parameter int LIMIT = 640,
  parameter int SIZE  = 32,
  parameter int SPEED = 2,
  parameter int POS0  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  output logic [9:0] pos,
  output logic       flip
);
  localparam logic [10:0] MAX_P = 11'(LIMIT - SIZE);
  localparam logic [10:0] SPD = 11'(SPEED);
  logic dir;
  logic [10:0] up;
  logic [9:0] next;
  always_comb begin
    up = {1'b0, pos} + SPD;
    flip = dir ? up >= MAX_P : {1'b0, pos} <= SPD;
    next = dir ? (flip ? MAX_P[9:0] : up[9:0]) : (flip ? '0 : pos - SPD[9:0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= 10'(POS0);
      dir <= 1'b1;
    end else if (load) begin
      pos <= next;
      dir <= dir ^ flip;
    end
  end
endmodule

// File: rtl/vga_bounce_renderer.sv
// vga_bounce_renderer: checkerboard + bouncing sprite pixel stage, 2-clock aligned pipeline; COLOR_CYCLE_EN rotates sprite colour on bounces
module vga_bounce_renderer
  import vga_bounce_renderer_pkg::*;
#(
  parameter int H_RES = H_RES_D,
  parameter int V_RES = V_RES_D,
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int SPEED = 2,
  parameter int SPR_X0 = 100,
  parameter int SPR_Y0 = 50,
  parameter logic [RGB_W-1:0] SPR_COLOR = SPR_COLOR_D,
  parameter logic [RGB_W-1:0] BG_A = BG_A_D,
  parameter logic [RGB_W-1:0] BG_B = BG_B_D
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             active_in,
  input  logic [9:0]       horizPos,
  input  logic [9:0]       vertPos,
  input  logic             pause,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_tick
);
  state_t state, state_nx;
  logic vsync_prev, load, flip_x, flip_y;
  logic [9:0] x, y;
  logic [RGB_W-1:0] spr_col;
  logic s1_hit, s1_chk, s1_act, s1_hs, s1_vs;
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state <= IDLE;
      vsync_prev <= 1'b1;
    end else begin
      state <= state_nx;
      vsync_prev <= vsync_in;
    end
  end
  // motion only moves on the vsync falling edge, then waits for vsync to rise again
  always_comb begin
    state_nx = state == IDLE ? ((!vsync_in && vsync_prev) ? UPDATE : IDLE)
             : state == UPDATE ? HOLD
             : (vsync_in ? IDLE : HOLD);
    frame_tick = state == UPDATE;
    load = frame_tick && !pause;
  end
  bounce_axis #(.LIMIT(H_RES), .SIZE(SPR_W), .SPEED(SPEED), .POS0(SPR_X0)) u_x (
    .clk(clk), .rst(sys_rst), .load(load), .pos(x), .flip(flip_x)
  );
  bounce_axis #(.LIMIT(V_RES), .SIZE(SPR_H), .SPEED(SPEED), .POS0(SPR_Y0)) u_y (
    .clk(clk), .rst(sys_rst), .load(load), .pos(y), .flip(flip_y)
  );
`ifdef COLOR_CYCLE_EN
  logic [1:0] col_idx;
  always_ff @(posedge clk) begin
    if (sys_rst) col_idx <= '0;
    else if (load && (flip_x || flip_y)) col_idx <= col_idx + 2'd1;
  end
  assign spr_col = rotl_col(SPR_COLOR, col_idx);
`else
  logic unused_flips;
  assign unused_flips = flip_x ^ flip_y;
  assign spr_col = SPR_COLOR;
`endif
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      {s1_hit, s1_chk, s1_act} <= '0;
      {s1_hs, s1_vs} <= 2'b11;
      {hsync_out, vsync_out} <= 2'b11;
      rgb <= '0;
    end else begin
      s1_hit <= {1'b0, horizPos} >= {1'b0, x} && {1'b0, horizPos} < {1'b0, x} + 11'(SPR_W)
             && {1'b0, vertPos} >= {1'b0, y} && {1'b0, vertPos} < {1'b0, y} + 11'(SPR_H);
      s1_chk <= horizPos[5] ^ vertPos[5];
      s1_act <= active_in;
      s1_hs <= hsync_in;
      s1_vs <= vsync_in;
      rgb <= !s1_act ? '0 : s1_hit ? spr_col : s1_chk ? BG_B : BG_A;
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
    end
  end
endmodule
